// File: rtl/ama_riscv_mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port around ama_riscv_mem_arbiter.
// The slave modport is the arbiter's view; master is the fetch/LSU/memory environment.
interface ama_riscv_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Every channel is valid/ready: a transfer happens in a cycle where both are high;
    // the sender holds its fields stable while valid is high and ready is low.
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic              imem_rsp_ready;
    logic [31:0]       imem_rsp_data;

    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [ADDR_W-1:0] dmem_req_addr;
    logic              dmem_req_we;
    logic [31:0]       dmem_req_wdata;
    logic [3:0]        dmem_req_wmask;
    logic              dmem_rsp_valid;
    logic              dmem_rsp_ready;
    logic [31:0]       dmem_rsp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_we;
    logic [31:0]       mem_req_wdata;
    logic [3:0]        mem_req_wmask;
    logic              mem_rsp_valid;
    logic              mem_rsp_ready;
    logic [31:0]       mem_rsp_data;

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_rsp_ready,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wmask,
        input  dmem_rsp_ready,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
        output mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output imem_req_valid, imem_req_addr, imem_rsp_ready,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wmask,
        output dmem_rsp_ready,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
        input  mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/ama_riscv_mem_arbiter.sv
// Shares one memory port between fetch (imem) and load/store (dmem): dmem-priority arbitration
// with an imem starvation limit, a one-entry request hold stage, and tag-FIFO response routing.
module ama_riscv_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MAX_OUT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    ama_riscv_mem_arbiter_if.slave       bus,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         proto_err
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int SC_W  = $clog2(STARVE_LIM + 1);

    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_we;
    logic [31:0]       hold_wdata;
    logic [3:0]        hold_wmask;

    logic [OUT_W-1:0]  outstanding_q;
    logic [SC_W-1:0]   starve_cnt;
    logic              proto_err_q;

    logic              tag_mem [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic load_en, read_ok, starve_hit, dmem_wins, imem_wins;
    logic imem_grant, dmem_grant, read_load, fifo_empty, head_tag, rsp_hs;

    // Read gate uses the registered count, so no path runs from mem_rsp to *_req_ready.
    assign load_en    = !hold_valid || bus.mem_req_ready;
    assign read_ok    = outstanding_q < OUT_W'(MAX_OUT);
    assign starve_hit = bus.imem_req_valid && (starve_cnt == SC_W'(STARVE_LIM));
    assign dmem_wins  = bus.dmem_req_valid && !starve_hit;
    assign imem_wins  = bus.imem_req_valid && !dmem_wins;
    assign dmem_grant = !rst && dmem_wins && load_en && (bus.dmem_req_we || read_ok);
    assign imem_grant = !rst && imem_wins && load_en && read_ok;
    assign read_load  = imem_grant || (dmem_grant && !bus.dmem_req_we);

    assign bus.imem_req_ready = imem_grant;
    assign bus.dmem_req_ready = dmem_grant;

    assign bus.mem_req_valid  = hold_valid;
    assign bus.mem_req_addr   = hold_addr;
    assign bus.mem_req_we     = hold_we;
    assign bus.mem_req_wdata  = hold_wdata;
    assign bus.mem_req_wmask  = hold_wmask;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_we    <= 1'b0;
            hold_wdata <= '0;
            hold_wmask <= '0;
        end else if (load_en) begin
            hold_valid <= imem_grant || dmem_grant;
            if (dmem_grant) begin
                hold_addr  <= bus.dmem_req_addr;
                hold_we    <= bus.dmem_req_we;
                hold_wdata <= bus.dmem_req_wdata;
                hold_wmask <= bus.dmem_req_wmask;
            end else if (imem_grant) begin
                hold_addr  <= bus.imem_req_addr;
                hold_we    <= 1'b0;
                hold_wdata <= '0;
                hold_wmask <= '0;
            end
        end
    end

    // The counter only ever runs while imem is waiting; it saturates because dmem loses at the limit.
    always_ff @(posedge clk) begin
        if (rst || !bus.imem_req_valid || imem_grant) begin
            starve_cnt <= '0;
        end else if (dmem_grant) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Every read in the hold stage or in flight owns one FIFO entry, so the count doubles as occupancy.
    assign fifo_empty = (outstanding_q == '0);
    assign head_tag   = tag_mem[rd_ptr];
    assign rsp_hs     = bus.mem_rsp_valid && bus.mem_rsp_ready && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            if (read_load && !rsp_hs) begin
                outstanding_q <= outstanding_q + 1'b1;
            end else if (!read_load && rsp_hs) begin
                outstanding_q <= outstanding_q - 1'b1;
            end
            if (read_load) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rsp_hs) begin
                rd_ptr <= (rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (bus.mem_rsp_valid && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && read_load) begin
            tag_mem[wr_ptr] <= dmem_grant;
        end
    end

    // An unexpected response is swallowed so the memory side never stalls on it.
    always_comb begin
        bus.imem_rsp_valid = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        bus.mem_rsp_ready  = 1'b1;
        bus.imem_rsp_data  = bus.mem_rsp_data;
        bus.dmem_rsp_data  = bus.mem_rsp_data;
        if (!rst && !fifo_empty) begin
            if (head_tag) begin
                bus.dmem_rsp_valid = bus.mem_rsp_valid;
                bus.mem_rsp_ready  = bus.dmem_rsp_ready;
            end else begin
                bus.imem_rsp_valid = bus.mem_rsp_valid;
                bus.mem_rsp_ready  = bus.imem_rsp_ready;
            end
        end
    end

    assign outstanding = outstanding_q;
    assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
// Directed bench for ama_riscv_mem_arbiter: inputs change on the falling edge, outputs checked 1ns later.
module tb_ama_riscv_mem_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] outstanding;
  logic       proto_err;
  int         n_vec = 0;
  int         n_err = 0;

  ama_riscv_mem_arbiter_if #(.ADDR_W(32)) bus ();

  ama_riscv_mem_arbiter #(.ADDR_W(32), .MAX_OUT(2), .STARVE_LIM(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic set_imem(input logic v, input logic [31:0] a);
    bus.imem_req_valid = v;
    bus.imem_req_addr  = a;
  endtask

  task automatic set_dmem(input logic v, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm);
    bus.dmem_req_valid = v;
    bus.dmem_req_we    = we;
    bus.dmem_req_addr  = a;
    bus.dmem_req_wdata = wd;
    bus.dmem_req_wmask = wm;
  endtask

  task automatic set_rsp(input logic v, input logic [31:0] d, input logic ir, input logic dr);
    bus.mem_rsp_valid  = v;
    bus.mem_rsp_data   = d;
    bus.imem_rsp_ready = ir;
    bus.dmem_rsp_ready = dr;
  endtask

  task automatic idle();
    set_imem(1'b0, 32'h0);
    set_dmem(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_rsp(1'b0, 32'h0, 1'b1, 1'b1);
    bus.mem_req_ready = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc();
    idle();
    rst = 1'b1;
    set_imem(1'b1, 32'h40);
    set_dmem(1'b1, 1'b0, 32'h80, 32'h0, 4'h0);
    cyc();
    cyc();
    #1;
    n_vec++;
    if (bus.imem_req_ready !== 1'b0 || bus.dmem_req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_ready: got i=%b d=%b exp 0 0", bus.imem_req_ready, bus.dmem_req_ready);
    end
    n_vec++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0 || bus.mem_req_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mem_req: got v=%b a=%h wd=%h exp 0 0 0", bus.mem_req_valid,
               bus.mem_req_addr, bus.mem_req_wdata);
    end
    n_vec++;
    if (outstanding !== 2'd0 || proto_err !== 1'b0 || bus.imem_rsp_valid !== 1'b0 ||
        bus.dmem_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got out=%0d perr=%b irv=%b drv=%b exp 0 0 0 0", outstanding,
               proto_err, bus.imem_rsp_valid, bus.dmem_rsp_valid);
    end
    idle();
    rst = 1'b0;
  endtask

  task automatic test_solo_fetch();
    do_reset();
    bus.mem_req_ready = 1'b1;
    set_imem(1'b1, 32'h100);
    #1;
    n_vec++;
    if (bus.imem_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL solo_accept: got %b exp 1", bus.imem_req_ready);
    end
    cyc();
    set_imem(1'b0, 32'h0);
    #1;
    n_vec++;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h100 || bus.mem_req_we !== 1'b0 ||
        outstanding !== 2'd1) begin
      n_err++;
      $display("FAIL solo_issue: got v=%b a=%h we=%b out=%0d exp 1 00000100 0 1", bus.mem_req_valid,
               bus.mem_req_addr, bus.mem_req_we, outstanding);
    end
    cyc();
    #1;
    n_vec++;
    if (bus.mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL solo_drained: got %b exp 0", bus.mem_req_valid);
    end
    cyc();
    set_rsp(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (bus.imem_rsp_valid !== 1'b1 || bus.imem_rsp_data !== 32'hDEADBEEF ||
        bus.dmem_rsp_valid !== 1'b0 || bus.mem_rsp_ready !== 1'b1) begin
      n_err++;
      $display("FAIL solo_rsp: got irv=%b d=%h drv=%b mrr=%b exp 1 deadbeef 0 1", bus.imem_rsp_valid,
               bus.imem_rsp_data, bus.dmem_rsp_valid, bus.mem_rsp_ready);
    end
    cyc();
    set_rsp(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (outstanding !== 2'd0) begin
      n_err++;
      $display("FAIL solo_out_zero: got %0d exp 0", outstanding);
    end
  endtask

  task automatic test_priority();
    byte got;
    byte exp;
    do_reset();
    bus.mem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      set_imem(1'b1, 32'h1000 + 32'(i * 4));
      set_dmem(1'b1, 1'b1, 32'h2000 + 32'(i * 4), 32'(i), 4'hF);
      #1;
      got = bus.dmem_req_ready ? "D" : (bus.imem_req_ready ? "I" : "-");
      exp = (i % 5 == 4) ? "I" : "D";
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL prio_grant[%0d]: got %c exp %c", i, got, exp);
      end
    end
    cyc();
    idle();
    #1;
    n_vec++;
    if (outstanding !== 2'd2) begin
      n_err++;
      $display("FAIL prio_out: got %0d exp 2", outstanding);
    end
  endtask

  task automatic test_read_cap();
    logic [2:0] got;
    do_reset();
    bus.mem_req_ready = 1'b1;
    set_dmem(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    #1;
    got[0] = bus.dmem_req_ready;
    cyc();
    set_dmem(1'b1, 1'b0, 32'h204, 32'h0, 4'h0);
    #1;
    got[1] = bus.dmem_req_ready;
    cyc();
    set_dmem(1'b1, 1'b0, 32'h208, 32'h0, 4'h0);
    #1;
    got[2] = bus.dmem_req_ready;
    n_vec++;
    if (got !== 3'b011 || outstanding !== 2'd2) begin
      n_err++;
      $display("FAIL cap_block: got ready=%b out=%0d exp 011 2", got, outstanding);
    end
    cyc();
    set_rsp(1'b1, 32'hA1, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (bus.dmem_req_ready !== 1'b0 || bus.dmem_rsp_valid !== 1'b1 || bus.dmem_rsp_data !== 32'hA1) begin
      n_err++;
      $display("FAIL cap_rsp_cycle: got rdy=%b rv=%b d=%h exp 0 1 000000a1", bus.dmem_req_ready,
               bus.dmem_rsp_valid, bus.dmem_rsp_data);
    end
    cyc();
    set_rsp(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (bus.dmem_req_ready !== 1'b1 || outstanding !== 2'd1) begin
      n_err++;
      $display("FAIL cap_release: got rdy=%b out=%0d exp 1 1", bus.dmem_req_ready, outstanding);
    end
    cyc();
    idle();
  endtask

  task automatic test_ordering();
    do_reset();
    bus.mem_req_ready = 1'b1;
    set_imem(1'b1, 32'h300);
    #1;
    n_vec++;
    if (bus.imem_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ord_a_accept: got %b exp 1", bus.imem_req_ready);
    end
    cyc();
    set_imem(1'b0, 32'h0);
    set_dmem(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    #1;
    n_vec++;
    if (bus.dmem_req_ready !== 1'b1 || bus.mem_req_addr !== 32'h300) begin
      n_err++;
      $display("FAIL ord_b_accept: got rdy=%b a=%h exp 1 00000300", bus.dmem_req_ready, bus.mem_req_addr);
    end
    cyc();
    set_dmem(1'b1, 1'b1, 32'h500, 32'h55, 4'hF);
    #1;
    n_vec++;
    if (bus.dmem_req_ready !== 1'b1 || bus.mem_req_addr !== 32'h400) begin
      n_err++;
      $display("FAIL ord_c_accept: got rdy=%b a=%h exp 1 00000400", bus.dmem_req_ready, bus.mem_req_addr);
    end
    cyc();
    idle();
    bus.mem_req_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.mem_req_we !== 1'b1 || bus.mem_req_addr !== 32'h500 || bus.mem_req_wdata !== 32'h55 ||
        bus.mem_req_wmask !== 4'hF || outstanding !== 2'd2) begin
      n_err++;
      $display("FAIL ord_c_issue: got we=%b a=%h wd=%h wm=%h out=%0d exp 1 00000500 00000055 f 2",
               bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask, outstanding);
    end
    cyc();
    set_rsp(1'b1, 32'h11, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (bus.imem_rsp_valid !== 1'b1 || bus.dmem_rsp_valid !== 1'b0 || bus.imem_rsp_data !== 32'h11) begin
      n_err++;
      $display("FAIL ord_rsp_a: got irv=%b drv=%b d=%h exp 1 0 00000011", bus.imem_rsp_valid,
               bus.dmem_rsp_valid, bus.imem_rsp_data);
    end
    cyc();
    set_rsp(1'b1, 32'h22, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (bus.imem_rsp_valid !== 1'b0 || bus.dmem_rsp_valid !== 1'b1 || bus.dmem_rsp_data !== 32'h22) begin
      n_err++;
      $display("FAIL ord_rsp_b: got irv=%b drv=%b d=%h exp 0 1 00000022", bus.imem_rsp_valid,
               bus.dmem_rsp_valid, bus.dmem_rsp_data);
    end
    cyc();
    set_rsp(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (outstanding !== 2'd0 || proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL ord_done: got out=%0d perr=%b exp 0 0", outstanding, proto_err);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mem_req_ready = 1'b0;
    set_dmem(1'b1, 1'b1, 32'h500, 32'h1234, 4'h3);
    cyc();
    for (int i = 0; i < 5; i++) begin
      set_imem(1'b1, 32'h700 + 32'(i));
      set_dmem(1'b1, 1'b1, 32'h504 + 32'(i * 4), 32'hFF00 + 32'(i), 4'hC);
      #1;
      n_vec++;
      if (bus.imem_req_ready !== 1'b0 || bus.dmem_req_ready !== 1'b0 || bus.mem_req_valid !== 1'b1 ||
          bus.mem_req_addr !== 32'h500 || bus.mem_req_wdata !== 32'h1234 || bus.mem_req_wmask !== 4'h3) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: got ir=%b dr=%b v=%b a=%h wd=%h wm=%h exp 0 0 1 00000500 00001234 3",
                 i, bus.imem_req_ready, bus.dmem_req_ready, bus.mem_req_valid, bus.mem_req_addr,
                 bus.mem_req_wdata, bus.mem_req_wmask);
      end
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.dmem_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got %b exp 1", bus.dmem_req_ready);
    end
    do_reset();
    bus.mem_req_ready = 1'b1;
    set_dmem(1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
    cyc();
    set_dmem(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cyc();
    set_rsp(1'b1, 32'h77, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (bus.mem_rsp_ready !== 1'b0 || bus.dmem_rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_rsp_hold: got mrr=%b drv=%b exp 0 1", bus.mem_rsp_ready, bus.dmem_rsp_valid);
    end
    cyc();
    #1;
    n_vec++;
    if (outstanding !== 2'd1 || bus.dmem_rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_no_pop: got out=%0d drv=%b exp 1 1", outstanding, bus.dmem_rsp_valid);
    end
    bus.dmem_rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.mem_rsp_ready !== 1'b1 || bus.dmem_rsp_data !== 32'h77) begin
      n_err++;
      $display("FAIL bp_rsp_take: got mrr=%b d=%h exp 1 00000077", bus.mem_rsp_ready, bus.dmem_rsp_data);
    end
    cyc();
    set_rsp(1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (outstanding !== 2'd0) begin
      n_err++;
      $display("FAIL bp_popped: got %0d exp 0", outstanding);
    end
  endtask

  task automatic test_reset_err();
    do_reset();
    bus.mem_req_ready = 1'b1;
    set_imem(1'b1, 32'h800);
    cyc();
    set_imem(1'b1, 32'h804);
    cyc();
    set_imem(1'b0, 32'h0);
    #1;
    n_vec++;
    if (outstanding !== 2'd2) begin
      n_err++;
      $display("FAIL err_two_out: got %0d exp 2", outstanding);
    end
    cyc();
    rst = 1'b1;
    set_imem(1'b1, 32'h808);
    #1;
    n_vec++;
    if (bus.imem_req_ready !== 1'b0 || bus.imem_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL err_in_rst: got ir=%b irv=%b exp 0 0", bus.imem_req_ready, bus.imem_rsp_valid);
    end
    cyc();
    cyc();
    rst = 1'b0;
    idle();
    #1;
    n_vec++;
    if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0 || outstanding !== 2'd0 ||
        proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_after_rst: got v=%b a=%h out=%0d perr=%b exp 0 0 0 0", bus.mem_req_valid,
               bus.mem_req_addr, outstanding, proto_err);
    end
    cyc();
    set_rsp(1'b1, 32'hBAD, 1'b1, 1'b1);
    #1;
    n_vec++;
    if (bus.imem_rsp_valid !== 1'b0 || bus.dmem_rsp_valid !== 1'b0 || bus.mem_rsp_ready !== 1'b1) begin
      n_err++;
      $display("FAIL err_drop: got irv=%b drv=%b mrr=%b exp 0 0 1", bus.imem_rsp_valid,
               bus.dmem_rsp_valid, bus.mem_rsp_ready);
    end
    cyc();
    set_rsp(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (proto_err !== 1'b1 || outstanding !== 2'd0) begin
        n_err++;
        $display("FAIL err_sticky[%0d]: got perr=%b out=%0d exp 1 0", i, proto_err, outstanding);
      end
      cyc();
    end
    do_reset();
    #1;
    n_vec++;
    if (proto_err !== 1'b0) begin
      n_err++;
      $display("FAIL err_cleared: got %b exp 0", proto_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_solo_fetch();
    test_priority();
    test_read_cap();
    test_ordering();
    test_backpressure();
    test_reset_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ama_riscv_mem_arbiter.md
# ama_riscv_mem_arbiter

Shares one memory port between the core's instruction-fetch requester (imem) and its load/store requester (dmem). Each cycle it picks one winner: fixed priority to dmem, with a starvation limit that guarantees imem a grant. The winning request is registered into a one-entry hold stage. Read responses come back in order and are routed to their originator through a tag FIFO. It sits between the fetch/LSU logic and a unified single-port memory, or a downstream cache.

## Interface
- ADDR_W, 32, request address width
- MAX_OUT, 2, maximum outstanding reads (tag FIFO depth, ≥1)
- STARVE_LIM, 4, consecutive dmem grants allowed while imem waits (≥1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imem_req_valid / imem_req_ready  in / out  1  fetch request handshake
- imem_req_addr  in  ADDR_W  fetch address (always a read)
- imem_rsp_valid / imem_rsp_ready  out / in  1  fetch response handshake
- imem_rsp_data  out  32  fetched instruction
- dmem_req_valid / dmem_req_ready  in / out  1  data request handshake
- dmem_req_addr  in  ADDR_W  data address
- dmem_req_we  in  1  1 = write, 0 = read
- dmem_req_wdata  in  32  write data
- dmem_req_wmask  in  4  byte write mask
- dmem_rsp_valid / dmem_rsp_ready  out / in  1  load response handshake
- dmem_rsp_data  out  32  load data
- mem_req_valid / mem_req_ready  out / in  1  shared-port request handshake
- mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask  out  ADDR_W/1/32/4  registered request fields
- mem_rsp_valid / mem_rsp_ready  in / out  1  shared-port response (reads only)
- mem_rsp_data  in  32  read data
- outstanding  out  $clog2(MAX_OUT+1)  reads in the hold stage plus reads in flight
- proto_err  out  1  sticky: mem_rsp_valid arrived while the tag FIFO was empty

## Operation
- Hold stage:
  - One register containing valid, addr, we, wdata, wmask and tag.
  - It can load when it is empty or is draining this cycle (mem_req_valid && mem_req_ready). This is load_en.
- Arbitration:
  - When both requesters are valid, dmem wins, unless starve_cnt == STARVE_LIM; then imem wins.
  - starve_cnt increments on each dmem grant made while imem_req_valid is high.
  - starve_cnt clears on an imem grant, or in any cycle where imem_req_valid is low.
- Read gating: a read may be granted only if the registered outstanding < MAX_OUT. Writes ignore this limit.
- If dmem is blocked, the arbiter does not grant anyone this cycle and does not fall back to imem. This keeps the grant decision independent of the read cap. Requests are never reordered.
- req_ready of the winner = load_en && read-gate. The loser's req_ready = 0. On the handshake, the request is captured into the hold stage.
- Tags: a read loaded into the hold stage pushes its tag (0 = imem, 1 = dmem) into the tag FIFO. Writes push nothing and expect no response.
- outstanding: increments on a read load and decrements on a mem_rsp handshake. If both happen in the same cycle, it is unchanged.
- Response routing (combinational):
  - FIFO head selects the destination.
  - The selected rsp_valid = mem_rsp_valid. Both rsp_data outputs = mem_rsp_data.
  - mem_rsp_ready = the selected requester's rsp_ready.
  - Pop the FIFO on the mem_rsp handshake.
- FIFO empty with mem_rsp_valid: set proto_err, mem_rsp_ready = 1 (response dropped), both rsp_valid = 0.
- Reset: hold stage empty, FIFO empty, outstanding = 0, starve_cnt = 0, proto_err = 0.
  - Outputs during and after reset: mem_req_valid = 0, imem_rsp_valid = dmem_rsp_valid = 0, both req_ready = 0 while rst is high, mem_req_* data fields = 0.
  - Reset mid-operation discards all in-flight tags. A response arriving after reset raises proto_err.

## Timing
- Requester handshake in cycle N → mem_req_valid high in N+1 with the captured fields. These are held stable until mem_req_ready.
- Back-to-back issue: with mem_req_ready held high, one request is accepted per cycle (full throughput).
- Combinational paths: mem_req_ready → *_req_ready, and mem_rsp_valid/ready ↔ *_rsp_valid/ready. No path exists from mem_rsp to *_req_ready, because the read gate uses the registered outstanding.
- Response latency through the block: 0 cycles.
- Read-cap boundary: outstanding == MAX_OUT with a response handshake in cycle N → a read can be granted in N+1, not in N.
- Starvation bound: imem waits at most STARVE_LIM dmem grants plus any cycles with the hold stage stalled.

## Test plan
- Solo fetch: imem reads 0x100, memory responds 2 cycles after accept with 0xDEADBEEF → mem_req_valid in N+1, imem_rsp_data = 0xDEADBEEF, dmem_rsp_valid stays 0.
- Priority/starvation (STARVE_LIM = 4): both requesters valid continuously, mem_req_ready = 1 → grant pattern D,D,D,D,I,D,D,D,D,I.
- Read cap (MAX_OUT = 2): three reads issued, memory withholds responses → third req_ready = 0 while outstanding = 2. First response returns → third read is accepted the next cycle.
- Ordering/routing: imem read A, dmem read B, dmem write C, memory returns 0x11 then 0x22 → imem gets 0x11, dmem gets 0x22, outstanding returns to 0, write produces no response.
- Backpressure: mem_req_ready = 0 for 5 cycles → mem_req_* stable, both req_ready = 0. dmem_rsp_ready = 0 → mem_rsp_ready = 0 and the FIFO does not pop.
- Reset/error: assert rst with 2 reads outstanding, then inject mem_rsp_valid → all outputs reset values, proto_err = 1 and stays high until the next rst.
